// File: rtl/mult_factorizer.sv
// ============================================================================
// Module      : mult_factorizer
// Description : Exhaustive sequential inverse of a WxW->2W unsigned multiplier;
//               tests one candidate pair (ca <= cb) per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_factorizer #(
    parameter int W            = 2,
    parameter int SKIP_TRIVIAL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] n,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [W-1:0]   a,
    output logic [W-1:0]   b
);

    // One spare counter bit lets MIN=2 exist even when W=1.
    localparam logic [W:0] c_min   = (W+1)'((SKIP_TRIVIAL != 0) ? 2 : 0);
    localparam logic [W:0] c_max   = (W+1)'((1 << W) - 1);
    localparam logic [W:0] c_one   = (W+1)'(1);
    localparam bit         c_empty = (SKIP_TRIVIAL != 0) && (W == 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    state_t         r_state;
    logic [2*W-1:0] r_n;
    logic [W:0]     r_ca;
    logic [W:0]     r_cb;

    logic [2*W+1:0] w_prod;
    logic           w_hit;
    logic           w_last;

    assign w_prod = r_ca * r_cb;
    assign w_hit  = (w_prod == {2'b00, r_n});
    assign w_last = (r_ca == c_max) && (r_cb == c_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_ca    <= '0;
            r_cb    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            found   <= 1'b0;
            a       <= '0;
            b       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_n     <= n;
                        r_ca    <= c_min;
                        r_cb    <= c_min;
                        found   <= 1'b0;
                        a       <= '0;
                        b       <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (!c_empty && w_hit) begin
                        a       <= r_ca[W-1:0];
                        b       <= r_cb[W-1:0];
                        found   <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (c_empty || w_last) begin
                        a       <= '0;
                        b       <= '0;
                        found   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cb != c_max) begin
                        r_cb <= r_cb + c_one;
                    end else begin
                        // Inner index restarts at the new outer index so a <= b.
                        r_ca <= r_ca + c_one;
                        r_cb <= r_ca + c_one;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
